// File: rtl/mac_operand_packer.sv
// mac_operand_packer: packs scalar A/B element pairs into 24-bit MAC operand
// words (INT4 x6, FP8 x3, BF16 x1) behind a one-entry output register.
// Optional build macro: MAC_PACK_STATS_EN adds saturating word/pad counters.
module mac_operand_packer #(
  parameter int IN_W   = 16,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_a,
  input  logic [IN_W-1:0]   in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_a,
  output logic [23:0]       out_b,
  output logic [1:0]        out_mode,
  output logic              out_last,
  output logic              err_mode,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_pads
);

  localparam logic [1:0] MODE_INT4 = 2'b00;
  localparam logic [1:0] MODE_FP8  = 2'b01;
  localparam logic [1:0] MODE_BF16 = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [23:0] pack_a_q, pack_a_d;
  logic [23:0] pack_b_q, pack_b_d;
  logic        out_valid_q, out_valid_d;
  logic [23:0] out_a_q, out_a_d;
  logic [23:0] out_b_q, out_b_d;
  logic [1:0]  out_mode_q, out_mode_d;
  logic        out_last_q, out_last_d;
  logic        out_pad_q, out_pad_d;
  logic        err_mode_q, err_mode_d;

  logic [1:0]  eff_mode;
  logic [2:0]  last_lane;
  logic [23:0] lane_a, lane_b;
  logic        reserved, is_last_lane, final_cand, accept, drain;

  // Element bits above the active lane width are intentionally ignored.
  logic unused_in_bits;
  assign unused_in_bits = ^{in_a, in_b};

  // Decode the mode for this beat, place the element in its lane and
  // decide whether the beat closes the word.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    eff_mode  = (cnt_q == 3'd0) ? cfg_mode : mode_q;
    reserved  = (eff_mode == MODE_RSVD);
    last_lane = 3'd0;
    lane_a    = 24'd0;
    lane_b    = 24'd0;
    case (eff_mode)
      MODE_INT4: begin
        last_lane = 3'd5;
        lane_a    = {20'd0, in_a[3:0]} << {cnt_q, 2'b00};
        lane_b    = {20'd0, in_b[3:0]} << {cnt_q, 2'b00};
      end
      MODE_FP8: begin
        last_lane = 3'd2;
        lane_a    = {16'd0, in_a[7:0]} << {cnt_q, 3'b000};
        lane_b    = {16'd0, in_b[7:0]} << {cnt_q, 3'b000};
      end
      MODE_BF16: begin
        last_lane = 3'd0;
        lane_a    = {8'd0, in_a[15:0]};
        lane_b    = {8'd0, in_b[15:0]};
      end
      default: ;
    endcase
    is_last_lane = (cnt_q == last_lane);
    final_cand   = !reserved && (is_last_lane || in_last);
    in_ready     = !final_cand || !out_valid_q || out_ready;
    accept       = in_valid && in_ready;
    drain        = out_valid_q && out_ready;
  end

  // Next-state: lane accumulation, word emission and output register hold.
  always_comb begin
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    pack_a_d    = pack_a_q;
    pack_b_d    = pack_b_q;
    out_valid_d = drain ? 1'b0 : out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_mode_d  = out_mode_q;
    out_last_d  = out_last_q;
    out_pad_d   = out_pad_q;
    err_mode_d  = err_mode_q;
    if (accept) begin
      if (cnt_q == 3'd0) mode_d = cfg_mode;
      if (reserved) begin
        err_mode_d = 1'b1;
      end else if (final_cand) begin
        out_a_d     = pack_a_q | lane_a;
        out_b_d     = pack_b_q | lane_b;
        out_mode_d  = eff_mode;
        out_last_d  = in_last;
        out_pad_d   = !is_last_lane;
        out_valid_d = 1'b1;
        cnt_d       = 3'd0;
        pack_a_d    = 24'd0;
        pack_b_d    = 24'd0;
      end else begin
        pack_a_d = pack_a_q | lane_a;
        pack_b_d = pack_b_q | lane_b;
        cnt_d    = cnt_q + 3'd1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      cnt_q       <= 3'd0;
      mode_q      <= MODE_INT4;
      pack_a_q    <= 24'd0;
      pack_b_q    <= 24'd0;
      out_valid_q <= 1'b0;
      out_a_q     <= 24'd0;
      out_b_q     <= 24'd0;
      out_mode_q  <= MODE_INT4;
      out_last_q  <= 1'b0;
      out_pad_q   <= 1'b0;
      err_mode_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      pack_a_q    <= pack_a_d;
      pack_b_q    <= pack_b_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_mode_q  <= out_mode_d;
      out_last_q  <= out_last_d;
      out_pad_q   <= out_pad_d;
      err_mode_q  <= err_mode_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_mode  = out_mode_q;
  assign out_last  = out_last_q;
  assign err_mode  = err_mode_q;

`ifdef MAC_PACK_STATS_EN
  logic [STAT_W-1:0] stat_words_q, stat_words_d;
  logic [STAT_W-1:0] stat_pads_q, stat_pads_d;

  // Saturating counters of emitted words and of zero-padded words.
  always_comb begin
    stat_words_d = stat_words_q;
    stat_pads_d  = stat_pads_q;
    if (drain && (stat_words_q != {STAT_W{1'b1}})) stat_words_d = stat_words_q + 1'b1;
    if (drain && out_pad_q && (stat_pads_q != {STAT_W{1'b1}})) stat_pads_d = stat_pads_q + 1'b1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_q <= '0;
      stat_pads_q  <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_pads_q  <= stat_pads_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_pads  = stat_pads_q;
`else
  logic unused_pad;
  assign unused_pad = out_pad_q;
  assign stat_words = '0;
  assign stat_pads  = '0;
`endif

endmodule
